time_param_loader: RTL and testbench

TIME_PARAM_LOADER -- requirements
Module: time_param_loader

---
 rtl/time_param_loader.sv | 194 +++++++++++++++++++
 tb/tb_time_param_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_param_loader.sv
// Sequences four 4-bit time parameters into a controller via Selector/Value/Reprogram handshakes.
// Optional macro TIME_PARAM_LOADER_MASK_EN adds Load_Mask to choose which indices are programmed.
module time_param_loader #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Load_Req,
    input  logic       Abort,
`ifdef TIME_PARAM_LOADER_MASK_EN
    input  logic [3:0] Load_Mask,
`endif
    input  logic [3:0] Param0,
    input  logic [3:0] Param1,
    input  logic [3:0] Param2,
    input  logic [3:0] Param3,
    output logic [1:0] Selector,
    output logic [3:0] Value,
    output logic       Reprogram,
    output logic       Busy,
    output logic       Done
);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("SETUP_CYCLES must be in 1..15");
    end
    if (PULSE_CYCLES < 2 || PULSE_CYCLES > 15) begin : g_bad_pulse
        $error("PULSE_CYCLES must be in 2..15");
    end

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] params_q [4];
    logic [3:0] params_d [4];
    logic [3:0] param_in [4];
    logic [3:0] mask_in;
    logic [1:0] sel_d;
    logic [3:0] val_d;
    logic       rep_d;
    logic       busy_d;
    logic       done_d;
    logic [2:0] first_hit;
    logic [2:0] next_hit;

`ifdef TIME_PARAM_LOADER_MASK_EN
    assign mask_in = Load_Mask;
`else
    assign mask_in = 4'hF;
`endif

    always_comb begin
        param_in[0] = Param0;
        param_in[1] = Param1;
        param_in[2] = Param2;
        param_in[3] = Param3;
    end

    // Lowest enabled index at or above start; result is {found, index}.
    function automatic logic [2:0] find_from(input logic [3:0] mask, input logic [2:0] start);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && mask[i] && (3'(i) >= start)) begin
                found = 1'b1;
                idx   = 2'(i);
            end
        end
        return {found, idx};
    endfunction

    assign first_hit = find_from(mask_in, 3'd0);
    assign next_hit  = find_from(mask_q, {1'b0, Selector} + 3'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 4'd1;
        mask_d   = mask_q;
        params_d = params_q;
        sel_d    = Selector;
        val_d    = Value;
        rep_d    = 1'b0;
        busy_d   = Busy;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = 4'd0;
                busy_d = 1'b0;
                if (Load_Req && !Abort) begin
                    params_d = param_in;
                    mask_d   = mask_in;
                    busy_d   = 1'b1;
                    if (first_hit[2]) begin
                        sel_d   = first_hit[1:0];
                        val_d   = param_in[first_hit[1:0]];
                        state_d = SETUP;
                    end else begin
                        // Nothing enabled: spend one busy cycle in NEXT, which then finishes.
                        state_d = NEXT;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = PULSE;
                    cnt_d   = 4'd0;
                    rep_d   = 1'b1;
                end
            end
            PULSE: begin
                rep_d = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = 4'd0;
                    rep_d   = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = NEXT;
                    cnt_d   = 4'd0;
                end
            end
            NEXT: begin
                cnt_d = 4'd0;
                if (next_hit[2]) begin
                    sel_d   = next_hit[1:0];
                    val_d   = params_q[next_hit[1:0]];
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over everything, leaves Selector/Value where they were.
        if (Abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            sel_d   = Selector;
            val_d   = Value;
            rep_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            mask_q    <= 4'd0;
            params_q  <= '{default: 4'd0};
            Selector  <= 2'd0;
            Value     <= 4'd0;
            Reprogram <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            params_q  <= params_d;
            Selector  <= sel_d;
            Value     <= val_d;
            Reprogram <= rep_d;
            Busy      <= busy_d;
            Done      <= done_d;
        end
    end

endmodule

// File: tb/tb_time_param_loader.sv
// Self-checking bench for time_param_loader: vector table plus scoreboard of expected Reprogram pulses and Done cycles.
// Mask vectors are added when TIME_PARAM_LOADER_MASK_EN is defined.
module tb_time_param_loader;

    localparam int S     = 2;
    localparam int P     = 4;
    localparam int ENTRY = 2 * S + P + 1;

    logic       clk      = 1'b0;
    logic       Reset    = 1'b0;
    logic       Load_Req = 1'b0;
    logic       Abort    = 1'b0;
`ifdef TIME_PARAM_LOADER_MASK_EN
    logic [3:0] Load_Mask = 4'hF;
`endif
    logic [3:0] Param0 = 4'd0;
    logic [3:0] Param1 = 4'd0;
    logic [3:0] Param2 = 4'd0;
    logic [3:0] Param3 = 4'd0;
    logic [1:0] Selector;
    logic [3:0] Value;
    logic       Reprogram;
    logic       Busy;
    logic       Done;

    time_param_loader #(.SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Load_Req  (Load_Req),
        .Abort     (Abort),
`ifdef TIME_PARAM_LOADER_MASK_EN
        .Load_Mask (Load_Mask),
`endif
        .Param0    (Param0),
        .Param1    (Param1),
        .Param2    (Param2),
        .Param3    (Param3),
        .Selector  (Selector),
        .Value     (Value),
        .Reprogram (Reprogram),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] val;
        int         cyc;
        int         width;
    } rise_t;

    typedef struct {
        logic [3:0] p0, p1, p2, p3;
        logic [3:0] mask;
        int         n_pulses;
        int         done_lat;
    } vec_t;

    rise_t sb[$];
    int    done_q[$];
    vec_t  vecs[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    rise_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_expect(input vec_t v, input int acc);
        int         k;
        rise_t      r;
        logic [3:0] p [4];
        k = 0;
        p = '{v.p0, v.p1, v.p2, v.p3};
        for (int i = 0; i < 4; i++) begin
            if (v.mask[i]) begin
                r.sel   = 2'(i);
                r.val   = p[i];
                r.cyc   = acc + S + ENTRY * k;
                r.width = P;
                sb.push_back(r);
                k++;
            end
        end
        done_q.push_back(acc + v.done_lat);
    endtask

    task automatic drive_params(input vec_t v);
        Param0 = v.p0;
        Param1 = v.p1;
        Param2 = v.p2;
        Param3 = v.p3;
`ifdef TIME_PARAM_LOADER_MASK_EN
        Load_Mask = v.mask;
`endif
    endtask

    task automatic check_idle(input string name);
        check(name, int'({Selector, Value, Reprogram, Busy, Done}), 0);
    endtask

    task automatic check_drain(input string name);
        check(name, sb.size() + done_q.size(), 0);
        sb.delete();
        done_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int acc;
        int r0;
        @(negedge clk);
        drive_params(v);
        Load_Req = 1'b1;
        acc = cyc + 1;
        r0  = rise_cnt;
        push_expect(v, acc);
        @(negedge clk);
        Load_Req = 1'b0;
        check({tag, "_busy_after_accept"}, int'(Busy), 1);
        wait_cyc(acc + v.done_lat);
        check({tag, "_done_at_latency"}, int'(Done), 1);
        check({tag, "_busy_at_done"}, int'(Busy), 0);
        wait_cyc(acc + v.done_lat + 3);
        check({tag, "_pulse_count"}, rise_cnt - r0, v.n_pulses);
        check({tag, "_reprogram_low"}, int'(Reprogram), 0);
        check_drain({tag, "_drain"});
    endtask

    // Monitor: every Reprogram pulse and every Done is matched against the scoreboard.
    initial begin : monitor
        logic       rep_prev;
        int         width;
        logic [1:0] hsel;
        logic [3:0] hval;
        rise_t      cur;
        rep_prev  = 1'b0;
        width     = 0;
        hsel      = 2'd0;
        hval      = 4'd0;
        cur.width = P;
        forever begin
            @(negedge clk);
            if (Reprogram && !rep_prev) begin
                rise_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_reprogram", 1, 0);
                    cur.width = P;
                end else begin
                    cur = sb.pop_front();
                    check("rise_selector", int'(Selector), int'(cur.sel));
                    check("rise_value", int'(Value), int'(cur.val));
                    check("rise_cycle", cyc, cur.cyc);
                end
                hsel  = Selector;
                hval  = Value;
                width = 1;
            end else if (Reprogram) begin
                width++;
                check("selector_stable_in_pulse", int'(Selector), int'(hsel));
                check("value_stable_in_pulse", int'(Value), int'(hval));
            end else if (rep_prev) begin
                check("pulse_width", width, cur.width);
            end
            if (Done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            rep_prev = Reprogram;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t  v;
        rise_t r;
        int    acc;

        vecs.push_back('{4'd5,  4'd3,  4'd2,  4'd9,  4'hF, 4, 36});
        vecs.push_back('{4'd0,  4'd15, 4'd0,  4'd15, 4'hF, 4, 36});
        vecs.push_back('{4'd15, 4'd14, 4'd13, 4'd12, 4'hF, 4, 36});
        vecs.push_back('{4'd1,  4'd2,  4'd4,  4'd8,  4'hF, 4, 36});
`ifdef TIME_PARAM_LOADER_MASK_EN
        vecs.push_back('{4'd5,  4'd3,  4'd2,  4'd9,  4'b1010, 2, 18});
        vecs.push_back('{4'd5,  4'd3,  4'd2,  4'd9,  4'b0000, 0, 1});
        vecs.push_back('{4'd9,  4'd8,  4'd7,  4'd6,  4'b0001, 1, 9});
`endif

        #12;
        check_idle("reset_outputs");
        @(negedge clk);
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("idle_after_release");

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Load_Req held for the whole load while Params change underneath.
        v = vecs[0];
        @(negedge clk);
        drive_params(v);
        Load_Req = 1'b1;
        acc = cyc + 1;
        push_expect(v, acc);
        wait_cyc(acc + 5);
        Param0 = 4'd1; Param1 = 4'd1; Param2 = 4'd1; Param3 = 4'd1;
        wait_cyc(acc + 15);
        Param1 = 4'd8; Param2 = 4'd7; Param3 = 4'd7;
        wait_cyc(acc + 36);
        check("held_req_busy_at_done", int'(Busy), 0);
        Load_Req = 1'b0;
        wait_cyc(acc + 40);
        check("held_req_stays_idle", int'(Busy), 0);
        check_drain("held_req_drain");

        // Abort during the second pulse.
        @(negedge clk);
        drive_params(vecs[0]);
        Load_Req = 1'b1;
        acc = cyc + 1;
        r = '{2'd0, 4'd5, acc + S, P};
        sb.push_back(r);
        r = '{2'd1, 4'd3, acc + S + ENTRY, 2};
        sb.push_back(r);
        @(negedge clk);
        Load_Req = 1'b0;
        wait_cyc(acc + 12);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        check("abort_reprogram", int'(Reprogram), 0);
        check("abort_busy", int'(Busy), 0);
        wait_cyc(acc + 45);
        check_drain("abort_drain");
        run_vec(vecs[1], "after_abort");

        // Load_Req together with Abort in IDLE is refused.
        @(negedge clk);
        drive_params(vecs[2]);
        Load_Req = 1'b1;
        Abort    = 1'b1;
        @(negedge clk);
        Load_Req = 1'b0;
        Abort    = 1'b0;
        check("abort_blocks_accept_busy", int'(Busy), 0);
        repeat (12) @(negedge clk);
        check_drain("abort_blocks_accept_drain");

        // Reset in the middle of the first pulse drops Reprogram at once.
        v = '{4'd7, 4'd6, 4'd5, 4'd4, 4'hF, 4, 36};
        @(negedge clk);
        drive_params(v);
        Load_Req = 1'b1;
        acc = cyc + 1;
        r = '{2'd0, 4'd7, acc + S, 2};
        sb.push_back(r);
        @(negedge clk);
        Load_Req = 1'b0;
        wait_cyc(acc + 3);
        #2;
        Reset = 1'b0;
        #1;
        check_idle("reset_in_pulse_outputs");
        @(negedge clk);
        #2;
        Reset = 1'b1;
        repeat (12) @(negedge clk);
        check_idle("reset_in_pulse_stays_idle");
        check_drain("reset_in_pulse_drain");

        // Reset during the third HOLD.
        @(negedge clk);
        drive_params(v);
        Load_Req = 1'b1;
        acc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            r.sel   = 2'(k);
            r.val   = (k == 0) ? 4'd7 : (k == 1) ? 4'd6 : 4'd5;
            r.cyc   = acc + S + ENTRY * k;
            r.width = P;
            sb.push_back(r);
        end
        @(negedge clk);
        Load_Req = 1'b0;
        wait_cyc(acc + 24);
        check("third_hold_selector", int'(Selector), 2);
        #2;
        Reset = 1'b0;
        #1;
        check_idle("reset_in_hold_outputs");
        repeat (3) @(negedge clk);
        check_idle("reset_held_outputs");
        #2;
        Reset = 1'b1;
        repeat (12) @(negedge clk);
        check_idle("reset_in_hold_stays_idle");
        check_drain("reset_in_hold_drain");
        run_vec(vecs[0], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
